// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one asyncfifo write port among NUM_REQ producers.
// A grant holds the port for up to MAX_BURST words so each producer's words stay contiguous in the FIFO.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic                          fifo_write,
    output logic [DATA_WIDTH-1:0]         fifo_write_data,
    input  logic                          fifo_can_write,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy,
    output logic                          dbg_state
);
    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] w_owner_nxt;
    logic [OW-1:0] r_last_owner;
    logic [OW-1:0] w_last_owner_nxt;
    logic [7:0]    r_burst_count;
    logic [7:0]    w_burst_count_nxt;
    logic          r_busy;
    logic          w_busy_nxt;

    logic [OW:0]   w_scan;
    logic [OW-1:0] w_sel;
    logic          w_any;
    logic          w_in_burst;
    logic          w_xfer;
    logic          w_release;
    logic [8:0]    w_count_inc;

    // Scan starts just past the previous owner, so a releasing owner ranks last.
    always_comb begin
        w_sel  = '0;
        w_any  = 1'b0;
        w_scan = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_scan = {1'b0, r_last_owner} + (OW+1)'(k);
            if (w_scan >= (OW+1)'(NUM_REQ)) begin
                w_scan = w_scan - (OW+1)'(NUM_REQ);
            end
            if (!w_any && req[w_scan[OW-1:0]]) begin
                w_any = 1'b1;
                w_sel = w_scan[OW-1:0];
            end
        end
    end

    // Handshake: a word moves on a cycle where the owner holds req (valid) and
    // fifo_can_write (ready) is high; req_ack/fifo_write mark exactly that cycle,
    // and an unacked word must stay stable until it is taken.
    assign w_in_burst  = (r_state == BURST) && reset_n;
    assign w_xfer      = w_in_burst && req[r_owner] && fifo_can_write;
    assign w_count_inc = {1'b0, r_burst_count} + 9'd1;
    assign w_release   = (w_xfer && req_last[r_owner])
                       || (w_xfer && (w_count_inc == 9'(MAX_BURST)))
                       || !req[r_owner];

    always_comb begin
        req_ack          = '0;
        req_ack[r_owner] = w_xfer;
    end

    assign fifo_write      = w_xfer;
    assign fifo_write_data = w_in_burst ? req_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH]
                                        : '0;

    always_comb begin
        w_state_nxt       = r_state;
        w_owner_nxt       = r_owner;
        w_last_owner_nxt  = r_last_owner;
        w_burst_count_nxt = r_burst_count;
        w_busy_nxt        = r_busy;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt       = BURST;
                    w_owner_nxt       = w_sel;
                    w_burst_count_nxt = '0;
                    w_busy_nxt        = 1'b1;
                end
            end
            BURST: begin
                if (w_xfer) begin
                    w_burst_count_nxt = r_burst_count + 8'd1;
                end
                if (w_release) begin
                    w_state_nxt      = IDLE;
                    w_last_owner_nxt = r_owner;
                    w_busy_nxt       = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_owner       <= '0;
            r_last_owner  <= OW'(NUM_REQ - 1);
            r_burst_count <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_last_owner  <= w_last_owner_nxt;
            r_burst_count <= w_burst_count_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    assign owner     = r_owner;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: per-cycle vector tables plus producer-driven
// sequences whose written words are checked against an expected queue.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [N-1:0]  req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ack;
  logic          fifo_write;
  logic [DW-1:0] fifo_write_data;
  logic          fifo_can_write;
  logic [1:0]    owner;
  logic          busy;
  logic          dbg_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req             (req),
    .req_last        (req_last),
    .req_data        (req_data),
    .req_ack         (req_ack),
    .fifo_write      (fifo_write),
    .fifo_write_data (fifo_write_data),
    .fifo_can_write  (fifo_can_write),
    .owner           (owner),
    .busy            (busy),
    .dbg_state       (dbg_state)
  );

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  last;
    logic          cw;
    int            src;
    logic [DW-1:0] dat;
    logic [N-1:0]  e_ack;
    logic          e_wr;
    logic          e_busy;
    logic [1:0]    e_owner;
  } vec_t;

  vec_t vt[$];

  // scoreboard entries are {source, data}
  logic [DW+1:0] exp_q[$];

  logic [DW-1:0] pw [N][16];
  bit            pl [N][16];
  int            pcnt [N];
  int            pptr [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_invariant(input string tag);
    check({tag, "_write_while_full"}, 32'(fifo_write & ~fifo_can_write), 32'd0);
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic cw,
                       input int src, input logic [DW-1:0] d);
    req            = r;
    req_last       = l;
    fifo_can_write = cw;
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW] = (i == src) ? d : (~d ^ DW'(i));
    end
  endtask

  task automatic add_v(input logic [N-1:0] r, input logic [N-1:0] l, input logic cw,
                       input int src, input logic [DW-1:0] d, input logic [N-1:0] e_ack,
                       input logic e_wr, input logic e_busy, input logic [1:0] e_owner);
    vec_t v;
    v.req = r; v.last = l; v.cw = cw; v.src = src; v.dat = d;
    v.e_ack = e_ack; v.e_wr = e_wr; v.e_busy = e_busy; v.e_owner = e_owner;
    vt.push_back(v);
  endtask

  task automatic apply_table(input string tag);
    for (int k = 0; k < vt.size(); k++) begin
      @(posedge clk); #2;
      drive(vt[k].req, vt[k].last, vt[k].cw, vt[k].src, vt[k].dat);
      #4;
      check($sformatf("%s[%0d]_ack", tag, k), 32'(req_ack), 32'(vt[k].e_ack));
      check($sformatf("%s[%0d]_write", tag, k), 32'(fifo_write), 32'(vt[k].e_wr));
      check($sformatf("%s[%0d]_busy", tag, k), 32'(busy), 32'(vt[k].e_busy));
      check($sformatf("%s[%0d]_state", tag, k), 32'(dbg_state), 32'(vt[k].e_busy));
      check($sformatf("%s[%0d]_owner", tag, k), 32'(owner), 32'(vt[k].e_owner));
      if (vt[k].e_wr) begin
        check($sformatf("%s[%0d]_data", tag, k), 32'(fifo_write_data), 32'(vt[k].dat));
      end
      check_invariant(tag);
    end
    vt.delete();
  endtask

  task automatic clear_prod();
    for (int i = 0; i < N; i++) begin
      pcnt[i] = 0;
      pptr[i] = 0;
    end
  endtask

  task automatic load(input int i, input logic [DW-1:0] base, input int n, input bit last_end);
    for (int k = 0; k < n; k++) begin
      pw[i][k] = base + DW'(k);
      pl[i][k] = last_end && (k == n - 1);
    end
    pcnt[i] = n;
    pptr[i] = 0;
  endtask

  task automatic expect_words(input int src, input logic [DW-1:0] base, input int from, input int n);
    for (int k = from; k < from + n; k++) begin
      exp_q.push_back({2'(src), base + DW'(k)});
    end
  endtask

  // Producers present their next word until acked; the bench plays the FIFO with can_write=1.
  task automatic run_prod(input string tag, input int max_cyc, output int cyc);
    logic [N-1:0]  r;
    logic [N-1:0]  l;
    logic [DW+1:0] e;
    bit            done;
    cyc  = 0;
    done = 0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(posedge clk); #2;
      r = '0;
      l = '0;
      for (int i = 0; i < N; i++) begin
        if (pptr[i] < pcnt[i]) begin
          r[i] = 1'b1;
          l[i] = pl[i][pptr[i]];
          req_data[i*DW +: DW] = pw[i][pptr[i]];
        end else begin
          req_data[i*DW +: DW] = '0;
        end
      end
      req            = r;
      req_last       = l;
      fifo_can_write = 1'b1;
      if (r == '0 && !busy) begin
        done = 1;
      end else begin
        cyc++;
        #4;
        check_invariant(tag);
        if (fifo_write) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_unexpected_write: actual=%0h required=no write", tag, fifo_write_data);
          end else begin
            e = exp_q.pop_front();
            check({tag, "_owner_data"}, 32'({owner, fifo_write_data}), 32'(e));
            check({tag, "_ack"}, 32'(req_ack), 32'(1) << e[DW+1:DW]);
          end
        end else begin
          check({tag, "_ack_idle"}, 32'(req_ack), 32'd0);
        end
        for (int i = 0; i < N; i++) begin
          if (req_ack[i] && pptr[i] < pcnt[i]) pptr[i]++;
        end
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: actual=%0d cycles required=completion", tag, max_cyc);
    end
    req      = '0;
    req_last = '0;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    req            = '0;
    req_last       = '0;
    req_data       = '0;
    fifo_can_write = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            cyc;
    logic [DW-1:0] d;

    // Reset state, with every requester asserting to prove ack/write are forced low.
    reset_n        = 1'b0;
    req            = '1;
    req_last       = '0;
    req_data       = '1;
    fifo_can_write = 1'b1;
    #3;
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_write", 32'(fifo_write), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    do_reset();

    // Single requester, three words with last on the third.
    add_v(4'b0001, 4'b0000, 1'b1, 0, 16'h1111, 4'b0000, 1'b0, 1'b0, 2'd0);
    add_v(4'b0001, 4'b0000, 1'b1, 0, 16'h1111, 4'b0001, 1'b1, 1'b1, 2'd0);
    add_v(4'b0001, 4'b0000, 1'b1, 0, 16'h2222, 4'b0001, 1'b1, 1'b1, 2'd0);
    add_v(4'b0001, 4'b0001, 1'b1, 0, 16'h3333, 4'b0001, 1'b1, 1'b1, 2'd0);
    add_v(4'b0000, 4'b0000, 1'b1, 0, 16'h0000, 4'b0000, 1'b0, 1'b0, 2'd0);
    apply_table("single");

    // Backpressure: MAX_BURST ends the first grant after face; d00b waits on can_write.
    add_v(4'b0010, 4'b0000, 1'b1, 1, 16'hdead, 4'b0000, 1'b0, 1'b0, 2'd0);
    add_v(4'b0010, 4'b0000, 1'b1, 1, 16'hdead, 4'b0010, 1'b1, 1'b1, 2'd1);
    add_v(4'b0010, 4'b0000, 1'b1, 1, 16'hbeef, 4'b0010, 1'b1, 1'b1, 2'd1);
    add_v(4'b0010, 4'b0000, 1'b1, 1, 16'hfeed, 4'b0010, 1'b1, 1'b1, 2'd1);
    add_v(4'b0010, 4'b0000, 1'b1, 1, 16'hface, 4'b0010, 1'b1, 1'b1, 2'd1);
    add_v(4'b0010, 4'b0000, 1'b0, 1, 16'hd00b, 4'b0000, 1'b0, 1'b0, 2'd1);
    add_v(4'b0010, 4'b0000, 1'b0, 1, 16'hd00b, 4'b0000, 1'b0, 1'b1, 2'd1);
    add_v(4'b0010, 4'b0010, 1'b0, 1, 16'hd00b, 4'b0000, 1'b0, 1'b1, 2'd1);
    add_v(4'b0010, 4'b0010, 1'b1, 1, 16'hd00b, 4'b0010, 1'b1, 1'b1, 2'd1);
    add_v(4'b0000, 4'b0000, 1'b1, 1, 16'h0000, 4'b0000, 1'b0, 1'b0, 2'd1);
    apply_table("backpressure");

    // Round-robin from reset: 0,2,0,2 in bursts of four with a bubble between grants.
    do_reset();
    clear_prod();
    load(0, 16'ha000, 8, 1'b0);
    load(2, 16'hc000, 8, 1'b0);
    expect_words(0, 16'ha000, 0, 4);
    expect_words(2, 16'hc000, 0, 4);
    expect_words(0, 16'ha000, 4, 4);
    expect_words(2, 16'hc000, 4, 4);
    run_prod("rr", 60, cyc);
    check("rr_cycles", 32'(cyc), 32'd20);
    check("rr_sb_empty", 32'(exp_q.size()), 32'd0);

    // Withdrawal: req3 drops after one word; pending req0 is served next.
    clear_prod();
    load(3, 16'h3330, 1, 1'b0);
    load(0, 16'h0a0a, 1, 1'b1);
    expect_words(3, 16'h3330, 0, 1);
    expect_words(0, 16'h0a0a, 0, 1);
    run_prod("withdraw", 30, cyc);
    check("withdraw_cycles", 32'(cyc), 32'd5);
    check("withdraw_sb_empty", 32'(exp_q.size()), 32'd0);

    // Async reset in the middle of req1's second word.
    @(posedge clk); #2;
    drive(4'b0010, 4'b0000, 1'b1, 1, 16'h1001);
    #4;
    check("arst_idle_write", 32'(fifo_write), 32'd0);
    @(posedge clk); #2;
    #4;
    check("arst_w1_write", 32'(fifo_write), 32'd1);
    check("arst_w1_data", 32'(fifo_write_data), 32'h1001);
    check("arst_w1_owner", 32'(owner), 32'd1);
    @(posedge clk); #2;
    drive(4'b0011, 4'b0000, 1'b1, 1, 16'h1002);
    #1;
    check("arst_w2_write", 32'(fifo_write), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_mid_write", 32'(fifo_write), 32'd0);
    check("arst_mid_ack", 32'(req_ack), 32'd0);
    check("arst_mid_busy", 32'(busy), 32'd0);
    check("arst_mid_owner", 32'(owner), 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    #4;
    check("arst_rel_busy", 32'(busy), 32'd0);
    check("arst_rel_write", 32'(fifo_write), 32'd0);
    @(posedge clk); #2;
    #4;
    d = ~16'h1002;
    check("arst_grant_owner", 32'(owner), 32'd0);
    check("arst_grant_busy", 32'(busy), 32'd1);
    check("arst_grant_ack", 32'(req_ack), 32'd1);
    check("arst_grant_data", 32'(fifo_write_data), 32'(d));
    @(posedge clk); #2;
    drive(4'b0000, 4'b0000, 1'b1, 0, 16'h0000);
    @(posedge clk); #6;
    check("arst_end_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
